// File: rtl/pc_gen.sv
// Program-counter generator: prioritised redirects with a pending slot, valid/ready
// toward fetch. Optional direct-mapped BTB built when PC_BTB_EN is defined.
module pc_gen #(
  parameter int unsigned              ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0]    RESET_VECTOR  = '0,
  parameter int unsigned              STEP          = 4,
  parameter int unsigned              JP_CH         = 2,
  parameter int unsigned              BTB_ENTRIES   = 16,
  parameter int unsigned              StallLevelLen = 3,
  parameter logic [StallLevelLen-1:0] Stall_Null    = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic [StallLevelLen-1:0]    stall_command,
  input  logic [JP_CH-1:0]            jp_valid,
  input  logic [JP_CH*ADDR_WIDTH-1:0] jp_target,
  input  logic                        pc_ready,
  input  logic                        btb_upd_valid,
  input  logic [ADDR_WIDTH-1:0]       btb_upd_pc,
  input  logic [ADDR_WIDTH-1:0]       btb_upd_target,
  input  logic                        btb_upd_taken,
  output logic [ADDR_WIDTH-1:0]       pc,
  output logic                        pc_valid,
  output logic                        pc_pred_taken,
  output logic                        pc_flush
);

  localparam logic [ADDR_WIDTH-1:0] STEP_W    = ADDR_WIDTH'(STEP);
  localparam logic [ADDR_WIDTH-1:0] STEP_MASK = ADDR_WIDTH'(STEP - 1);

  logic                  win_v;
  logic [ADDR_WIDTH-1:0] win_t;
  logic                  pend_v;
  logic [ADDR_WIDTH-1:0] pend_t;
  logic [ADDR_WIDTH-1:0] next_pc;

  // Lowest-index valid channel wins; target forced onto a STEP boundary.
  always_comb begin
    win_v = 1'b0;
    win_t = '0;
    for (int unsigned i = 0; i < JP_CH; i++) begin
      if (jp_valid[i] && !win_v) begin
        win_v = 1'b1;
        win_t = jp_target[i*ADDR_WIDTH +: ADDR_WIDTH] & ~STEP_MASK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_VECTOR;
      pc_valid <= 1'b0;
      pc_flush <= 1'b0;
      pend_v   <= 1'b0;
      pend_t   <= '0;
    end else begin
      pc_valid <= 1'b1;
      pc_flush <= 1'b0;
      if (rdy) begin
        if (win_v) begin
          pc       <= win_t;
          pend_v   <= 1'b0;
          pc_flush <= 1'b1;
        end else if (pend_v) begin
          pc       <= pend_t;
          pend_v   <= 1'b0;
          pc_flush <= 1'b1;
        end else if (pc_valid && pc_ready && stall_command == Stall_Null) begin
          pc <= next_pc;
        end
      end else if (win_v) begin
        pend_v <= 1'b1;
        pend_t <= win_t;
      end
    end
  end

`ifdef PC_BTB_EN
  localparam int unsigned OFS  = $clog2(STEP);
  localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = ADDR_WIDTH - OFS - IDXW;

  logic [BTB_ENTRIES-1:0] btb_v;
  logic [TAGW-1:0]        btb_tag [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0]  btb_tgt [BTB_ENTRIES];
  logic [IDXW-1:0]        rd_idx, wr_idx;
  logic [TAGW-1:0]        rd_tag, wr_tag;
  logic                   hit;

  assign rd_idx = pc[OFS +: IDXW];
  assign rd_tag = pc[ADDR_WIDTH-1 -: TAGW];
  assign wr_idx = btb_upd_pc[OFS +: IDXW];
  assign wr_tag = btb_upd_pc[ADDR_WIDTH-1 -: TAGW];

  assign hit           = btb_v[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign pc_pred_taken = hit;
  assign next_pc       = hit ? btb_tgt[rd_idx] : pc + STEP_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_v <= '0;
    end else if (btb_upd_valid && rdy) begin
      if (btb_upd_taken)
        btb_v[wr_idx] <= 1'b1;
      else if (btb_tag[wr_idx] == wr_tag)
        btb_v[wr_idx] <= 1'b0;
    end
  end

  // Tag/target need no reset: an entry is only consulted through its valid bit.
  always_ff @(posedge clk) begin
    if (btb_upd_valid && rdy && btb_upd_taken) begin
      btb_tag[wr_idx] <= wr_tag;
      btb_tgt[wr_idx] <= btb_upd_target;
    end
  end
`else
  logic        unused_btb;
  logic [31:0] unused_btb_depth;

  assign unused_btb       = ^{btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken};
  assign unused_btb_depth = BTB_ENTRIES;
  assign pc_pred_taken    = 1'b0;
  assign next_pc          = pc + STEP_W;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: vector table for redirect/pending/stall behaviour, plus
// hand sequences for mid-operation reset, 8-bit wrap and (when built) the BTB.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, rdy, pc_ready;
  logic [2:0]  stall_command;
  logic [1:0]  jp_valid;
  logic [63:0] jp_target;
  logic        btb_upd_valid, btb_upd_taken;
  logic [31:0] btb_upd_pc, btb_upd_target;
  logic [31:0] pc;
  logic        pc_valid, pc_pred_taken, pc_flush;

  logic [1:0]  jv8;
  logic [15:0] jt8;
  logic [7:0]  pc8;
  logic        pv8, pp8, pf8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_WIDTH(32), .STEP(4), .JP_CH(2), .BTB_ENTRIES(4), .StallLevelLen(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_command(stall_command),
    .jp_valid(jp_valid), .jp_target(jp_target), .pc_ready(pc_ready),
    .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken),
    .pc(pc), .pc_valid(pc_valid), .pc_pred_taken(pc_pred_taken), .pc_flush(pc_flush)
  );

  pc_gen #(.ADDR_WIDTH(8), .STEP(4), .JP_CH(2), .BTB_ENTRIES(4), .StallLevelLen(3)) dut8 (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_command(stall_command),
    .jp_valid(jv8), .jp_target(jt8), .pc_ready(pc_ready),
    .btb_upd_valid(1'b0), .btb_upd_pc(8'h00), .btb_upd_target(8'h00), .btb_upd_taken(1'b0),
    .pc(pc8), .pc_valid(pv8), .pc_pred_taken(pp8), .pc_flush(pf8)
  );

  typedef struct {
    logic        rdy;
    logic [2:0]  stall;
    logic        pr;
    logic [1:0]  jv;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] epc;
    logic        ef;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(logic r, logic [2:0] s, logic p, logic [1:0] j,
                              logic [31:0] a, logic [31:0] b, logic [31:0] e, logic f);
    vec_t v;
    v.rdy = r; v.stall = s; v.pr = p; v.jv = j; v.t0 = a; v.t1 = b; v.epc = e; v.ef = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect0(input logic [31:0] t);
    jp_valid  = 2'b01;
    jp_target = {32'h0, t};
  endtask

  task automatic no_redirect();
    jp_valid  = 2'b00;
    jp_target = '0;
  endtask

  task automatic btb_upd(input logic v, input logic [31:0] p, input logic [31:0] t, input logic tk);
    btb_upd_valid = v; btb_upd_pc = p; btb_upd_target = t; btb_upd_taken = tk;
  endtask

  initial begin
    logic btb_on;
`ifdef PC_BTB_EN
    btb_on = 1'b1;
`else
    btb_on = 1'b0;
`endif
    //              rdy  stall pr  jv     t0       t1       exp pc   flush
    tbl[0]  = mk(1, 0, 1, 2'b00, 32'h0,   32'h0,   32'h0,   0); // valid still low
    tbl[1]  = mk(1, 0, 1, 2'b00, 32'h0,   32'h0,   32'h4,   0);
    tbl[2]  = mk(1, 0, 1, 2'b00, 32'h0,   32'h0,   32'h8,   0);
    tbl[3]  = mk(1, 0, 1, 2'b00, 32'h0,   32'h0,   32'hC,   0);
    tbl[4]  = mk(1, 0, 1, 2'b11, 32'h100, 32'h200, 32'h100, 1);
    tbl[5]  = mk(1, 0, 1, 2'b00, 32'h0,   32'h0,   32'h104, 0);
    tbl[6]  = mk(1, 0, 1, 2'b01, 32'h103, 32'h0,   32'h100, 1);
    tbl[7]  = mk(1, 1, 1, 2'b00, 32'h0,   32'h0,   32'h100, 0);
    tbl[8]  = mk(1, 1, 1, 2'b10, 32'h0,   32'h300, 32'h300, 1);
    tbl[9]  = mk(1, 0, 0, 2'b00, 32'h0,   32'h0,   32'h300, 0);
    tbl[10] = mk(1, 0, 1, 2'b00, 32'h0,   32'h0,   32'h304, 0);
    tbl[11] = mk(0, 0, 1, 2'b00, 32'h0,   32'h0,   32'h304, 0);
    tbl[12] = mk(0, 0, 1, 2'b10, 32'h0,   32'h40,  32'h304, 0);
    tbl[13] = mk(0, 0, 1, 2'b00, 32'h0,   32'h0,   32'h304, 0);
    tbl[14] = mk(1, 0, 1, 2'b00, 32'h0,   32'h0,   32'h40,  1);
    tbl[15] = mk(1, 0, 1, 2'b00, 32'h0,   32'h0,   32'h44,  0);
    tbl[16] = mk(0, 0, 1, 2'b10, 32'h0,   32'h40,  32'h44,  0);
    tbl[17] = mk(1, 0, 1, 2'b01, 32'h80,  32'h0,   32'h80,  1);
    tbl[18] = mk(1, 0, 1, 2'b00, 32'h0,   32'h0,   32'h84,  0);
    tbl[19] = mk(0, 0, 1, 2'b01, 32'h200, 32'h0,   32'h84,  0);
    tbl[20] = mk(0, 0, 1, 2'b10, 32'h0,   32'h300, 32'h84,  0);
    tbl[21] = mk(1, 0, 1, 2'b00, 32'h0,   32'h0,   32'h300, 1);
    tbl[22] = mk(1, 0, 1, 2'b00, 32'h0,   32'h0,   32'h304, 0);

    rst = 1'b1; rdy = 1'b1; pc_ready = 1'b1; stall_command = 3'd0;
    no_redirect();
    btb_upd(1'b0, 32'h0, 32'h0, 1'b0);
    jv8 = 2'b00; jt8 = '0;
    tick(); tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'b0, pc_valid}, 32'd0);
    chk("reset_flush", {31'b0, pc_flush}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      rdy           = tbl[i].rdy;
      stall_command = tbl[i].stall;
      pc_ready      = tbl[i].pr;
      jp_valid      = tbl[i].jv;
      jp_target     = {tbl[i].t1, tbl[i].t0};
      tick();
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].epc);
      chk($sformatf("vec%0d_flush", i), {31'b0, pc_flush}, {31'b0, tbl[i].ef});
      chk($sformatf("vec%0d_valid", i), {31'b0, pc_valid}, 32'd1);
      chk($sformatf("vec%0d_pred", i), {31'b0, pc_pred_taken}, 32'd0);
    end

    // Reset beats both a pending redirect and a live one on the same edge.
    rdy = 1'b0; redirect0(32'h500);
    tick();
    chk("rstseq_pend_pc", pc, 32'h304);
    rst = 1'b1; rdy = 1'b1; redirect0(32'h600);
    tick();
    chk("rstseq_pc", pc, 32'h0);
    chk("rstseq_valid", {31'b0, pc_valid}, 32'd0);
    chk("rstseq_flush", {31'b0, pc_flush}, 32'd0);
    rst = 1'b0; no_redirect();
    tick();
    chk("rstseq_after_pc", pc, 32'h0);
    chk("rstseq_after_valid", {31'b0, pc_valid}, 32'd1);
    chk("rstseq_after_flush", {31'b0, pc_flush}, 32'd0);
    tick();
    chk("rstseq_step_pc", pc, 32'h4);

    // 8-bit wrap.
    jv8 = 2'b01; jt8 = {8'h00, 8'hFC};
    tick();
    chk("wrap_load", {24'b0, pc8}, 32'hFC);
    jv8 = 2'b00; jt8 = '0;
    tick();
    chk("wrap_next", {24'b0, pc8}, 32'h00);

    // BTB: install 0x10->0x80 while redirecting to 0x10.
    btb_upd(1'b1, 32'h10, 32'h80, 1'b1); redirect0(32'h10);
    tick();
    chk("btb_a_pc", pc, 32'h10);
    chk("btb_a_pred", {31'b0, pc_pred_taken}, {31'b0, btb_on});
    btb_upd(1'b0, 32'h0, 32'h0, 1'b0); no_redirect();
    tick();
    chk("btb_a_next", pc, btb_on ? 32'h80 : 32'h14);
    chk("btb_a_next_pred", {31'b0, pc_pred_taken}, 32'd0);

    // Aliasing install 0x50->0xA0 evicts 0x10.
    btb_upd(1'b1, 32'h50, 32'hA0, 1'b1); redirect0(32'h10);
    tick();
    chk("btb_b_pc", pc, 32'h10);
    chk("btb_b_pred", {31'b0, pc_pred_taken}, 32'd0);
    btb_upd(1'b0, 32'h0, 32'h0, 1'b0); no_redirect();
    tick();
    chk("btb_b_next", pc, 32'h14);

    redirect0(32'h50);
    tick();
    chk("btb_c_pc", pc, 32'h50);
    chk("btb_c_pred", {31'b0, pc_pred_taken}, {31'b0, btb_on});
    // Not-taken update invalidates while fetch holds.
    no_redirect(); pc_ready = 1'b0; btb_upd(1'b1, 32'h50, 32'h0, 1'b0);
    tick();
    chk("btb_c_hold_pc", pc, 32'h50);
    chk("btb_c_inval_pred", {31'b0, pc_pred_taken}, 32'd0);
    pc_ready = 1'b1; btb_upd(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("btb_c_next", pc, 32'h54);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch front end; successor to the single-jump PC register. Drives the fetch address and a valid/ready handshake toward instruction fetch, and arbitrates among several prioritised redirect sources. Redirects arriving while the memory side is not ready are held in a pending register rather than lost. An optional direct-mapped branch target buffer (BTB) supplies a predicted next PC.

## Interface
- `ADDR_WIDTH`, 32: PC width in bits (`RAMAddrLen` in the core build).
- `RESET_VECTOR`, 0: PC value after reset.
- `STEP`, 4: sequential increment. Power of two, at least 1.
- `JP_CH`, 2: number of redirect channels. Index 0 has the highest priority.
- `BTB_ENTRIES`, 16: BTB depth. Power of two, at least 2. Used only with `PC_BTB_EN`.

Ports:
- `clk` input 1: clock, all state on posedge.
- `rst` input 1: synchronous, active-high reset.
- `rdy` input 1: global ready. When 0, no architectural state advances.
- `stall_command` input `StallLevelLen`: pipeline stall level. The PC advances only when it equals `Stall_Null`.
- `jp_valid` input `JP_CH`: per-channel redirect request.
- `jp_target` input `JP_CH*ADDR_WIDTH`: channel i target at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `pc_ready` input 1: fetch accepts the current PC.
- `btb_upd_valid` input 1: BTB update strobe.
- `btb_upd_pc` input `ADDR_WIDTH`: PC of the resolved branch.
- `btb_upd_target` input `ADDR_WIDTH`: resolved target.
- `btb_upd_taken` input 1: 1 = install entry, 0 = invalidate entry.
- `pc` output `ADDR_WIDTH`: current fetch address.
- `pc_valid` output 1: `pc` is offered to fetch.
- `pc_pred_taken` output 1: `pc`'s successor was taken from the BTB.
- `pc_flush` output 1: one-cycle pulse, high the cycle after `pc` was loaded by a redirect.

## Operation
- Winning redirect: the lowest index i with `jp_valid[i]`=1. Its target has the low log2(`STEP`) bits cleared.
- Pending register `pend_v`/`pend_t` captures the winner whenever `rdy`=0. A newer winner overwrites an older pending one.
- Priority each posedge, rdy=1:
  1. A live redirect loads its target; `pend_v` is cleared.
  2. Otherwise, if `pend_v`, `pend_t` is loaded and `pend_v` is cleared.
  3. Otherwise, if `pc_valid && pc_ready && stall_command==Stall_Null`, `pc` loads next_pc.
  4. Otherwise, `pc` holds.
- next_pc is the BTB target on a BTB hit; otherwise `pc + STEP`, truncated to `ADDR_WIDTH` (wraps modulo 2^`ADDR_WIDTH`).
- `pc_pred_taken` is combinational from the BTB lookup of the current `pc`.
- Redirects (steps 1 and 2) ignore `pc_ready` and `stall_command`.
- `pc_flush` is registered: it is 1 the cycle after step 1 or step 2 fired, else 0.
- `pc_valid`:
  - 0 during reset and the first cycle after reset.
  - 1 from then on, held by the register.
  - Unaffected by `rdy`.

BTB (only with `PC_BTB_EN`):
- Index = `pc[log2(STEP)+log2(BTB_ENTRIES)-1 : log2(STEP)]`; tag = the remaining upper bits; one valid bit per entry.
- Hit = entry valid and tag matches.
- Update on posedge when `btb_upd_valid && rdy`: taken writes tag, target and valid=1; not-taken clears valid only if the tag matches.
- Lookup and update in the same cycle: lookup sees pre-update contents (no bypass).

## Timing
- Reset values: `pc`=`RESET_VECTOR`, `pc_valid`=0, `pc_flush`=0, `pend_v`=0, all BTB valid bits=0.
- Reset asserted mid-operation overrides every rule in the same edge, including a live redirect and a pending one.
- Redirect latency: `jp_valid` at edge N (rdy=1) gives `pc`=target after edge N, with `pc_flush`=1 for that same cycle.
- Redirect during `rdy`=0: target appears one edge after `rdy` returns to 1, unless a new live redirect wins that edge.
- Sequential throughput: one PC per cycle while ready, unstalled and accepted.
- BTB update visible to lookup one cycle after the update edge.
- All outputs except `pc_pred_taken` come from registers.

## Configuration
- `PC_BTB_EN` defined: BTB storage and lookup are built as described above.
- `PC_BTB_EN` undefined:
  - No BTB storage; `BTB_ENTRIES` is unused.
  - `btb_upd_*` inputs are ignored.
  - `pc_pred_taken` is tied 0.
  - next_pc is always `pc + STEP`.

## Test plan
- Reset, then `pc_ready`=1, no stall: after reset `pc`=0x0, `pc_valid`=0 for one cycle, then `pc` = 0x0, 0x4, 0x8, 0xC on successive cycles.
- `jp_valid`=2'b11 with targets 0x100 and 0x200: next `pc`=0x100 and `pc_flush`=1 for one cycle. Target 0x103 on ch0: `pc`=0x100.
- `rdy`=0 for 3 cycles with ch1 redirect to 0x40 in the middle: `pc` frozen throughout; `pc`=0x40 on the first edge with `rdy`=1. A ch0 redirect to 0x80 on that edge gives 0x80 instead.
- `stall_command`≠`Stall_Null` or `pc_ready`=0: `pc` holds. A redirect still loads during a stall.
- `ADDR_WIDTH`=8, `pc`=0xFC, `STEP`=4: next `pc`=0x00.
- With `PC_BTB_EN`, `BTB_ENTRIES`=4:
  - Install 0x10→0x80: fetch after 0x10 is 0x80 and `pc_pred_taken`=1.
  - Install 0x50→0xA0, which aliases the index with a different tag: 0x10 then misses and its successor is 0x14.
  - A not-taken update for 0x50 invalidates the entry.
